// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Integer register file (x0 hard-wired to zero) with two
//             combinational read ports, one write port with write-through
//             bypass, and a per-register busy scoreboard with population
//             count. Asynchronous active-high reset.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            flush,
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] rf_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;

   // Writes to x0 are discarded everywhere, so qualify once here.
   logic wr_en;
   logic iss_en;
   assign wr_en  = we && (waddr != '0);
   assign iss_en = issue_valid && (issue_rd != '0);

   // Next register-file contents: single write port, x0 pinned to zero.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         rf_d[i] = rf_q[i];
      end
      if (wr_en) begin
         rf_d[waddr] = wdata;
      end
      rf_d[0] = '0;
   end

   // Register-file storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   // Next scoreboard state: write-back clears, then issue sets so a new
   // producer to the same register wins; flush overrides both.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[waddr] = 1'b0;
      end
      if (iss_en) begin
         busy_d[issue_rd] = 1'b1;
      end
      if (flush) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   // Population count of the next scoreboard, registered alongside it.
   always_comb begin
      count_d = '0;
      for (int i = 1; i < NREGS; i++) begin
         count_d = count_d + (AW+1)'(busy_d[i]);
      end
   end

   // Scoreboard and busy-count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_count = count_q;

   // Read port 1: bypass a same-cycle write; a forwarded value never blocks.
   // Outputs are forced to zero while reset is held so the bypass path
   // cannot leak wdata during reset.
   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      if (!reset && (rs1_addr != '0)) begin
         rs1_data = (wr_en && (waddr == rs1_addr)) ? wdata : rf_q[rs1_addr];
         rs1_busy = busy_q[rs1_addr] && !(we && (waddr == rs1_addr));
      end
   end

   // Read port 2: identical behaviour to port 1.
   always_comb begin
      rs2_data = '0;
      rs2_busy = 1'b0;
      if (!reset && (rs2_addr != '0)) begin
         rs2_data = (wr_en && (waddr == rs2_addr)) ? wdata : rf_q[rs2_addr];
         rs2_busy = busy_q[rs2_addr] && !(we && (waddr == rs2_addr));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb: directed vector table,
//             asynchronous-reset sequence and model-checked random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [AW-1:0]   rs1_addr = '0;
   logic [AW-1:0]   rs2_addr = '0;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            we = 1'b0;
   logic [AW-1:0]   waddr = '0;
   logic [XLEN-1:0] wdata = '0;
   logic            issue_valid = 1'b0;
   logic [AW-1:0]   issue_rd = '0;
   logic            flush = 1'b0;
   logic [AW:0]     busy_count;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .we(we), .waddr(waddr), .wdata(wdata),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .flush(flush), .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic            b1;
      logic            b2;
      logic [AW:0]     cnt;
   } exp_t;

   typedef struct {
      logic            we;
      logic [AW-1:0]   waddr;
      logic [XLEN-1:0] wdata;
      logic            iv;
      logic [AW-1:0]   ird;
      logic            fl;
      logic [AW-1:0]   a1;
      logic [AW-1:0]   a2;
      exp_t            e;
   } vec_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // reference model state for the random phase
   logic [XLEN-1:0] m_rf   [NREGS];
   logic            m_busy [NREGS];

   function automatic vec_t mk(input logic w, input int wa, input logic [XLEN-1:0] wd,
                               input logic iv, input int ird, input logic fl,
                               input int a1, input int a2,
                               input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                               input logic b1, input logic b2, input int cnt);
      vec_t v;
      v.we = w; v.waddr = AW'(wa); v.wdata = wd;
      v.iv = iv; v.ird = AW'(ird); v.fl = fl;
      v.a1 = AW'(a1); v.a2 = AW'(a2);
      v.e.d1 = d1; v.e.d2 = d2; v.e.b1 = b1; v.e.b2 = b2; v.e.cnt = (AW+1)'(cnt);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      we = v.we; waddr = v.waddr; wdata = v.wdata;
      issue_valid = v.iv; issue_rd = v.ird; flush = v.fl;
      rs1_addr = v.a1; rs2_addr = v.a2;
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0;
      issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   // Pop the oldest expectation and compare against the live outputs.
   task automatic sample(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++; n_miss++;
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      e = sb.pop_front();
      n_vec++;
      if (rs1_data !== e.d1 || rs2_data !== e.d2 || rs1_busy !== e.b1 ||
          rs2_busy !== e.b2 || busy_count !== e.cnt) begin
         n_miss++;
         $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b cnt=%0d, want d1=%h d2=%h b1=%b b2=%b cnt=%0d",
                  name, rs1_data, rs2_data, rs1_busy, rs2_busy, busy_count,
                  e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
   endtask

   // Drive one vector on the falling edge, check before the rising edge.
   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      drive(v);
      sb.push_back(v.e);
      #1;
      sample(name);
   endtask

   task automatic expect_zero(input string name);
      exp_t z;
      z.d1 = '0; z.d2 = '0; z.b1 = 1'b0; z.b2 = 1'b0; z.cnt = '0;
      sb.push_back(z);
      sample(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   localparam logic [XLEN-1:0] DB = 64'hDEADBEEF_CAFEF00D;
   localparam logic [XLEN-1:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      vec_t tbl [24];
      vec_t v;
      exp_t e;

      //          we wa wdata iv ird fl a1 a2  d1    d2    b1 b2 cnt
      tbl[0]  = mk(0, 0, 0,    0, 0, 0, 0, 0,  0,    0,    0, 0, 0);
      tbl[1]  = mk(1, 5, DB,   0, 0, 0, 5, 0,  DB,   0,    0, 0, 0);
      tbl[2]  = mk(0, 0, 0,    0, 0, 0, 5, 5,  DB,   DB,   0, 0, 0);
      tbl[3]  = mk(1, 0, FF,   1, 0, 0, 0, 5,  0,    DB,   0, 0, 0);
      tbl[4]  = mk(0, 0, 0,    0, 0, 0, 0, 0,  0,    0,    0, 0, 0);
      tbl[5]  = mk(1, 7, 1,    0, 0, 0, 7, 0,  1,    0,    0, 0, 0);
      tbl[6]  = mk(1, 7, 42,   0, 0, 0, 7, 7,  42,   42,   0, 0, 0);
      tbl[7]  = mk(0, 0, 0,    1, 3, 0, 3, 7,  0,    42,   0, 0, 0);
      tbl[8]  = mk(0, 0, 0,    0, 0, 0, 3, 7,  0,    42,   1, 0, 1);
      tbl[9]  = mk(1, 3, 'h33, 0, 0, 0, 3, 3,  'h33, 'h33, 0, 0, 1);
      tbl[10] = mk(0, 0, 0,    0, 0, 0, 3, 0,  'h33, 0,    0, 0, 0);
      tbl[11] = mk(0, 0, 0,    1, 9, 0, 9, 0,  0,    0,    0, 0, 0);
      tbl[12] = mk(1, 9, 'h99, 1, 9, 0, 9, 9,  'h99, 'h99, 0, 0, 1);
      tbl[13] = mk(0, 0, 0,    0, 0, 0, 9, 0,  'h99, 0,    1, 0, 1);
      tbl[14] = mk(0, 0, 0,    1, 1, 0, 1, 9,  0,    'h99, 0, 1, 1);
      tbl[15] = mk(0, 0, 0,    1, 2, 0, 1, 2,  0,    0,    1, 0, 2);
      tbl[16] = mk(0, 0, 0,    1, 4, 0, 2, 4,  0,    0,    1, 0, 3);
      tbl[17] = mk(0, 0, 0,    1, 6, 1, 4, 6,  0,    0,    1, 0, 4);
      tbl[18] = mk(0, 0, 0,    0, 0, 0, 6, 9,  0,    'h99, 0, 0, 0);
      tbl[19] = mk(0, 0, 0,    1, 10,0, 10,0,  0,    0,    0, 0, 0);
      tbl[20] = mk(0, 0, 0,    1, 10,0, 10,0,  0,    0,    1, 0, 1);
      tbl[21] = mk(0, 0, 0,    0, 0, 0, 10,0,  0,    0,    1, 0, 1);
      tbl[22] = mk(1, 10,'hAA, 0, 0, 1, 10,0,  'hAA, 0,    0, 0, 1);
      tbl[23] = mk(0, 0, 0,    0, 0, 0, 10,5,  'hAA, DB,   0, 0, 0);

      // ---------------- reset state, held across edges ----------------
      idle();
      we = 1'b1; waddr = 5'd4; wdata = FF; issue_valid = 1'b1; issue_rd = 5'd4;
      rs1_addr = 5'd4; rs2_addr = 5'd4;
      repeat (2) @(negedge clk);
      #1 expect_zero("in_reset");
      @(negedge clk);
      reset = 1'b0;
      idle();

      // ---------------- directed table ----------------
      for (int i = 0; i < 24; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // ---------------- asynchronous reset mid-operation ----------------
      for (int i = 1; i < NREGS; i++) begin
         @(negedge clk);
         idle();
         we = 1'b1; waddr = AW'(i); wdata = {32'hA5A5_0000, 32'(i)};
      end
      for (int i = 11; i <= 13; i++) begin
         @(negedge clk);
         idle();
         issue_valid = 1'b1; issue_rd = AW'(i);
      end
      v = mk(1, 1, 'h1234, 1, 14, 0, 11, 1, {32'hA5A5_0000, 32'd11}, 'h1234, 1, 0, 3);
      apply(v, "pre_reset");
      #1 reset = 1'b1;
      #1 expect_zero("reset_async");
      @(posedge clk);
      #1 expect_zero("reset_edge");
      @(negedge clk);
      reset = 1'b0;
      idle();
      for (int i = 1; i < NREGS; i++) begin
         @(negedge clk);
         rs1_addr = AW'(i);
         rs2_addr = AW'(NREGS - i);
         #1 expect_zero($sformatf("post_reset_x%0d", i));
      end

      // ---------------- random traffic against a reference model ----------------
      for (int i = 0; i < NREGS; i++) begin
         m_rf[i] = '0;
         m_busy[i] = 1'b0;
      end
      for (int n = 0; n < 400; n++) begin
         int cnt;
         @(negedge clk);
         we          = ($urandom_range(0, 1) == 1);
         waddr       = AW'($urandom_range(0, NREGS - 1));
         wdata       = {$urandom(), $urandom()};
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_rd    = AW'($urandom_range(0, NREGS - 1));
         flush       = ($urandom_range(0, 15) == 0);
         rs1_addr    = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREGS - 1));
         rs2_addr    = ($urandom_range(0, 3) == 0) ? issue_rd : AW'($urandom_range(0, NREGS - 1));

         e.d1 = (rs1_addr == 0) ? '0 : (we && waddr == rs1_addr) ? wdata : m_rf[rs1_addr];
         e.d2 = (rs2_addr == 0) ? '0 : (we && waddr == rs2_addr) ? wdata : m_rf[rs2_addr];
         e.b1 = m_busy[rs1_addr] && !(we && waddr == rs1_addr);
         e.b2 = m_busy[rs2_addr] && !(we && waddr == rs2_addr);
         cnt = 0;
         for (int k = 0; k < NREGS; k++) cnt += m_busy[k] ? 1 : 0;
         e.cnt = (AW+1)'(cnt);
         sb.push_back(e);
         #1 sample($sformatf("rand%0d", n));

         if (we && waddr != 0) begin
            m_rf[waddr]   = wdata;
            m_busy[waddr] = 1'b0;
         end
         if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
         if (flush) begin
            for (int k = 0; k < NREGS; k++) m_busy[k] = 1'b0;
         end
      end

      @(negedge clk);
      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
